// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0
// ============================================================================
module md_unit #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MD_OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    input  logic        D_MD,
    output logic        busy,
    output logic [31:0] MD_OUT,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_stall
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Low 64 bits of the extended product equal the signed product when signed.
    assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
    assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide on magnitudes so INT_MIN / -1 wraps cleanly to 0x80000000.
    assign w_a_neg   = r_signed & r_a[31];
    assign w_b_neg   = r_signed & r_b[31];
    assign w_a_mag   = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag   = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag   = w_a_mag / w_divisor;
    assign w_r_mag   = w_a_mag % w_divisor;
    assign w_quo     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= 32'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && !cancel) begin
                        case (MD_OP)
                            3'b000, 3'b001: begin
                                r_a      <= A;
                                r_b      <= B;
                                r_signed <= ~MD_OP[0];
                                r_cnt    <= 32'(MULT_CYC);
                                r_state  <= c_MUL;
                            end
                            3'b010, 3'b011: begin
                                r_a      <= A;
                                r_b      <= B;
                                r_signed <= ~MD_OP[0];
                                r_cnt    <= 32'(DIV_CYC);
                                r_state  <= c_DIV;
                            end
                            3'b100:  r_hi <= A;
                            3'b101:  r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                c_MUL, c_DIV: begin
                    r_cnt <= r_cnt - 32'd1;
                    if (r_cnt == 32'd1) begin
                        r_state <= c_IDLE;
                        if (r_state == c_MUL) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_b != 32'd0) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != c_IDLE);
    assign HI       = r_hi;
    assign LO       = r_lo;
    assign md_stall = D_MD & (busy | (start & ~cancel));
    assign MD_OUT   = (MD_OP == 3'b110) ? r_hi :
                      (MD_OP == 3'b111) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Brief    : Self-checking bench for md_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_md_unit;

    localparam int unsigned MULT_CYC = 5;
    localparam int unsigned DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  MD_OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        D_MD;
    logic        busy;
    logic [31:0] MD_OUT;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        md_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .MD_OP(MD_OP), .A(A), .B(B),
        .cancel(cancel), .D_MD(D_MD), .busy(busy), .MD_OUT(MD_OUT),
        .HI(HI), .LO(LO), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference behaviour expressed directly as MIPS arithmetic.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2: if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            3'd3: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_cycles(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1) return int'(MULT_CYC);
        if (op == 3'd2 || op == 3'd3) return int'(DIV_CYC);
        return 0;
    endfunction

    // Issues one op and counts the cycles busy stays high (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic canc, output int cycles);
        MD_OP  = op;
        A      = a;
        B      = b;
        cancel = canc;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cancel = 1'b0;
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        MD_OP = 3'd6;
        #1;
        n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", HI); end
        n_tests++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", LO); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", md_stall); end
        n_tests++; if (MD_OUT !== 32'd0) begin n_fail++; $display("FAIL reset_mdout: got %h want 0", MD_OUT); end
        run_op(3'd4, 32'hAAAA5555, 32'd0, 1'b0, cyc);
        run_op(3'd5, 32'h5555AAAA, 32'd0, 1'b0, cyc);
        MD_OP = 3'd2; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_tests++; if (HI !== 32'd0 || LO !== 32'd0) begin n_fail++; $display("FAIL midreset_hilo: got %h/%h want 0/0", HI, LO); end
        repeat (12) begin @(posedge clk); #1; end
        n_tests++; if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_late: got %h/%h busy %b want 0/0 busy 0", HI, LO, busy); end
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult();
        int cyc;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
        n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL mult_cycles: got %0d want 5", cyc); end
        n_tests++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_result: got %h/%h want ffffffff/fffffffa", HI, LO); end
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
        n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL multu_cycles: got %0d want 5", cyc); end
        n_tests++; if (HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_result: got %h/%h want 00000002/fffffffa", HI, LO); end
        model_apply(3'd1, 32'hFFFFFFFE, 32'd3);
    endtask

    task automatic test_div();
        int cyc;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, cyc);
        n_tests++; if (cyc != 10) begin n_fail++; $display("FAIL div_cycles: got %0d want 10", cyc); end
        n_tests++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_result: got %h/%h want ffffffff/fffffffd", HI, LO); end
        run_op(3'd4, 32'h11, 32'd0, 1'b0, cyc);
        run_op(3'd5, 32'h22, 32'd0, 1'b0, cyc);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, cyc);
        n_tests++; if (cyc != 10) begin n_fail++; $display("FAIL divu0_cycles: got %0d want 10", cyc); end
        n_tests++; if (HI !== 32'h11 || LO !== 32'h22) begin n_fail++; $display("FAIL divu0_result: got %h/%h want 00000011/00000022", HI, LO); end
        m_hi = 32'h11;
        m_lo = 32'h22;
    endtask

    task automatic test_mthi_mtlo();
        MD_OP = 3'd4; A = 32'h12345678; start = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (HI !== 32'h12345678 || busy !== 1'b0) begin n_fail++; $display("FAIL mthi: got %h busy %b want 12345678 busy 0", HI, busy); end
        MD_OP = 3'd5; A = 32'h9ABCDEF0;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++; if (LO !== 32'h9ABCDEF0 || busy !== 1'b0) begin n_fail++; $display("FAIL mtlo: got %h busy %b want 9abcdef0 busy 0", LO, busy); end
        MD_OP = 3'd6; #1;
        n_tests++; if (MD_OUT !== 32'h12345678) begin n_fail++; $display("FAIL mfhi: got %h want 12345678", MD_OUT); end
        MD_OP = 3'd7; #1;
        n_tests++; if (MD_OUT !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mflo: got %h want 9abcdef0", MD_OUT); end
        MD_OP = 3'd0; #1;
        n_tests++; if (MD_OUT !== 32'd0) begin n_fail++; $display("FAIL mdout_other: got %h want 0", MD_OUT); end
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_stall();
        D_MD = 1'b1;
        MD_OP = 3'd0; A = 32'd1234; B = 32'd5678; start = 1'b1;
        #1;
        n_tests++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b want 1", md_stall); end
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (md_stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy%0d: got %b want 1", i, md_stall); end
            @(posedge clk); #1;
        end
        n_tests++; if (md_stall !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b busy %b want 0/0", md_stall, busy); end
        model_apply(3'd0, 32'd1234, 32'd5678);
        n_tests++; if (HI !== m_hi || LO !== m_lo) begin n_fail++; $display("FAIL stall_result: got %h/%h want %h/%h", HI, LO, m_hi, m_lo); end
        MD_OP = 3'd2; A = 32'd99; B = 32'd3; start = 1'b1; cancel = 1'b1;
        #1;
        n_tests++; if (md_stall !== 1'b0) begin n_fail++; $display("FAIL cancel_stall: got %b want 0", md_stall); end
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        n_tests++; if (busy !== 1'b0 || md_stall !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got busy %b stall %b want 0/0", busy, md_stall); end
        n_tests++; if (HI !== m_hi || LO !== m_lo) begin n_fail++; $display("FAIL cancel_hilo: got %h/%h want %h/%h", HI, LO, m_hi, m_lo); end
        D_MD = 1'b0;
    endtask

    task automatic test_operand_change();
        logic [31:0] a0;
        logic [31:0] b0;
        int cyc;
        a0 = $urandom; b0 = $urandom;
        MD_OP = 3'd0; A = a0; B = b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 200) begin
            A = $urandom; B = $urandom;
            cyc++;
            @(posedge clk); #1;
        end
        model_apply(3'd0, a0, b0);
        n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL opchg_cycles: got %0d want 5", cyc); end
        n_tests++; if (HI !== m_hi || LO !== m_lo) begin n_fail++; $display("FAIL opchg_result: got %h/%h want %h/%h", HI, LO, m_hi, m_lo); end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc);
        n_tests++; if (HI !== 32'd0 || LO !== 32'h80000000) begin n_fail++; $display("FAIL div_overflow: got %h/%h want 00000000/80000000", HI, LO); end
        m_hi = 32'd0;
        m_lo = 32'h80000000;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        canc;
        int          cyc;
        int          want;
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 5));
            a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            canc = ($urandom_range(0, 4) == 0);
            if (busy) begin
                n_tests++; n_fail++;
                $display("FAIL rnd_start_while_busy: busy %b want 0 before issue", busy);
            end
            run_op(op, a, b, canc, cyc);
            want = canc ? 0 : exp_cycles(op);
            if (!canc) model_apply(op, a, b);
            n_tests++; if (cyc != want) begin n_fail++; $display("FAIL rnd%0d_cycles op %0d: got %0d want %0d", n, op, cyc, want); end
            n_tests++; if (HI !== m_hi) begin n_fail++; $display("FAIL rnd%0d_hi op %0d a %h b %h: got %h want %h", n, op, a, b, HI, m_hi); end
            n_tests++; if (LO !== m_lo) begin n_fail++; $display("FAIL rnd%0d_lo op %0d a %h b %h: got %h want %h", n, op, a, b, LO, m_lo); end
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        D_MD   = 1'b0;
        MD_OP  = 3'd0;
        A      = 32'd0;
        B      = 32'd0;
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_stall();
        test_operand_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
